// File: rtl/dpram_pkg.sv
// Shared types and defaults for the dual-port RAM port-0 burst sequencer.
package dpram_pkg;

    localparam int unsigned DEF_DATA_WIDTH    = 8;
    localparam int unsigned DEF_ADDRESS_WIDTH = 8;

    localparam logic DIR_WRITE = 1'b0;
    localparam logic DIR_READ  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        FINISH
    } burst_state_t;

endpackage

// File: rtl/dpram_obuf.sv
// Read-data output buffer: small synchronous FIFO with first-word fall-through.
module dpram_obuf #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic [DATA_WIDTH-1:0]        data_i,
    input  logic                         pop_i,
    output logic [DATA_WIDTH-1:0]        data_o,
    output logic [$clog2(DEPTH):0]       count_o,
    output logic                         empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full;
    logic                  do_push;
    logic                  do_pop;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    // A push into a full buffer is fine when the same edge frees the head slot.
    assign do_push = push_i & (~full | do_pop);

    assign data_o  = empty_o ? '0 : mem[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/dpram_burst_ctrl.sv
// Port-0 burst sequencer: turns a (base, len, dir) command into registered RAM
// port-0 cycles, fed by a write stream and returning reads on a buffered stream.
module dpram_burst_ctrl
    import dpram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int unsigned OBUF_DEPTH    = 4
) (
    input  logic                     clk_0,
    input  logic                     rst_n_0,
    input  logic                     start,
    input  logic                     dir,
    input  logic [ADDRESS_WIDTH-1:0] base_addr,
    input  logic [ADDRESS_WIDTH:0]   len,
    output logic                     busy,
    output logic                     done,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_WIDTH-1:0]    s_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_WIDTH-1:0]    m_data,
    output logic                     ram_cs,
    output logic                     ram_we,
    output logic                     ram_oe,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]    ram_din,
    input  logic [DATA_WIDTH-1:0]    ram_dout
);

    localparam int unsigned CW = $clog2(OBUF_DEPTH) + 1;
    localparam int unsigned LW = ADDRESS_WIDTH + 1;

    burst_state_t             state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [LW-1:0]            issue_rem_q, issue_rem_d;
    logic [LW-1:0]            pop_rem_q, pop_rem_d;
    logic                     ram_cs_q, ram_cs_d;
    logic                     ram_we_q, ram_we_d;
    logic                     ram_oe_q, ram_oe_d;
    logic [ADDRESS_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0]    ram_din_q, ram_din_d;
    logic                     rd_pend_q, rd_pend_d;

    logic [CW-1:0]            buf_count;
    logic                     buf_empty;
    logic                     pop;
    logic                     rd_issued;
    logic [1:0]               in_flight;
    logic [CW:0]              occupancy;
    logic                     can_issue;

    // A read is in flight from its issue edge until its data lands in the buffer.
    assign rd_issued = ram_cs_q & ram_oe_q;
    assign in_flight = {1'b0, rd_issued} + {1'b0, rd_pend_q};
    assign occupancy = {1'b0, buf_count} + (CW + 1)'(in_flight);
    assign can_issue = occupancy < (CW + 1)'(OBUF_DEPTH);

    assign m_valid = ~buf_empty;
    assign pop     = m_valid & m_ready;

    dpram_obuf #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (OBUF_DEPTH)
    ) u_obuf (
        .clk_i  (clk_0),
        .rst_ni (rst_n_0),
        .push_i (rd_pend_q),
        .data_i (ram_dout),
        .pop_i  (pop),
        .data_o (m_data),
        .count_o(buf_count),
        .empty_o(buf_empty)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        issue_rem_d = issue_rem_q;
        pop_rem_d   = pop_rem_q;
        ram_cs_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_oe_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        rd_pend_d   = rd_issued;
        s_ready     = 1'b0;
        done        = 1'b0;
        busy        = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    issue_rem_d = len;
                    pop_rem_d   = len;
                    if (len == '0) begin
                        state_d = FINISH;
                    end else if (dir == DIR_READ) begin
                        state_d = READ;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                s_ready = (issue_rem_q != '0);
                if (s_valid && s_ready) begin
                    ram_cs_d    = 1'b1;
                    ram_we_d    = 1'b1;
                    ram_addr_d  = addr_q;
                    ram_din_d   = s_data;
                    addr_d      = addr_q + ADDRESS_WIDTH'(1);
                    issue_rem_d = issue_rem_q - LW'(1);
                    if (issue_rem_q == LW'(1)) begin
                        state_d = FINISH;
                    end
                end
            end
            READ: begin
                if ((issue_rem_q != '0) && can_issue) begin
                    ram_cs_d    = 1'b1;
                    ram_oe_d    = 1'b1;
                    ram_addr_d  = addr_q;
                    addr_d      = addr_q + ADDRESS_WIDTH'(1);
                    issue_rem_d = issue_rem_q - LW'(1);
                end
                if (pop) begin
                    pop_rem_d = pop_rem_q - LW'(1);
                    if (pop_rem_q == LW'(1)) begin
                        state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_0 or negedge rst_n_0) begin
        if (!rst_n_0) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            issue_rem_q <= '0;
            pop_rem_q   <= '0;
            ram_cs_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_oe_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            rd_pend_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            issue_rem_q <= issue_rem_d;
            pop_rem_q   <= pop_rem_d;
            ram_cs_q    <= ram_cs_d;
            ram_we_q    <= ram_we_d;
            ram_oe_q    <= ram_oe_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            rd_pend_q   <= rd_pend_d;
        end
    end

    assign ram_cs   = ram_cs_q;
    assign ram_we   = ram_we_q;
    assign ram_oe   = ram_oe_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;

endmodule

// File: tb/tb_dpram_burst_ctrl.sv
// Self-checking bench for dpram_burst_ctrl: RAM model on port 0, reference
// memory image updated per burst, randomized data and stream handshakes.
module tb_dpram_burst_ctrl;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int OD = 4;
    localparam int NWORDS = 1 << AW;

    logic          clk_0 = 1'b0;
    logic          rst_n_0 = 1'b0;
    logic          start = 1'b0;
    logic          dir = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;
    logic          busy, done;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          ram_cs, ram_we, ram_oe;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout = '0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [DW-1:0] ram_arr [NWORDS];
    logic [DW-1:0] ref_mem [NWORDS];

    int            wr_cyc_q[$];
    logic [AW-1:0] wr_addr_q[$];
    logic [DW-1:0] wr_data_q[$];
    int            rd_cyc_q[$];
    int            done_q[$];

    dpram_burst_ctrl #(
        .DATA_WIDTH   (DW),
        .ADDRESS_WIDTH(AW),
        .OBUF_DEPTH   (OD)
    ) dut (
        .clk_0    (clk_0),
        .rst_n_0  (rst_n_0),
        .start    (start),
        .dir      (dir),
        .base_addr(base_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .ram_cs   (ram_cs),
        .ram_we   (ram_we),
        .ram_oe   (ram_oe),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    always #5 clk_0 = ~clk_0;

    always @(posedge clk_0) cyc <= cyc + 1;

    // Port-0 RAM behaviour: write on cs&we, read data one clock after cs&oe.
    always @(posedge clk_0) begin
        if (ram_cs) begin
            if (ram_we) ram_arr[ram_addr] <= ram_din;
            if (ram_oe) ram_dout <= ram_arr[ram_addr];
        end
    end

    always @(negedge clk_0) begin
        if (rst_n_0) begin
            if (ram_cs && ram_we) begin
                wr_cyc_q.push_back(cyc);
                wr_addr_q.push_back(ram_addr);
                wr_data_q.push_back(ram_din);
            end
            if (ram_cs && ram_oe) rd_cyc_q.push_back(cyc);
            if (done) done_q.push_back(cyc);
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_0);
        #1;
    endtask

    task automatic clear_mon();
        wr_cyc_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_cyc_q.delete();
        done_q.delete();
    endtask

    task automatic issue(input logic d, input logic [AW-1:0] b, input int l, output int t0);
        start     = 1'b1;
        dir       = d;
        base_addr = b;
        len       = (AW + 1)'(l);
        tick();
        start     = 1'b0;
        dir       = 1'($urandom);
        base_addr = AW'($urandom);
        len       = (AW + 1)'($urandom);
        t0        = cyc;
    endtask

    // vmode: 0 continuous, 1 alternate on/off, 2 random valid.
    task automatic run_write(input logic [AW-1:0] b, input int l, input int vmode,
                             input int seq, input int poke);
        logic [DW-1:0] data[$];
        int            acc[$];
        int            t0, k, budget, idx;
        logic          rdy;
        for (int i = 0; i < l; i++) data.push_back(seq != 0 ? DW'(i) : DW'($urandom));
        clear_mon();
        issue(1'b0, b, l, t0);
        k = 0;
        budget = 0;
        while (k < l && budget < 300) begin
            case (vmode)
                0:       s_valid = 1'b1;
                1:       s_valid = (budget % 2 == 0);
                default: s_valid = 1'($urandom);
            endcase
            s_data = s_valid ? data[k] : DW'($urandom);
            if (poke != 0 && budget == 2) begin
                start = 1'b1;
                dir   = 1'b1;
                len   = (AW + 1)'(1);
            end
            rdy = s_ready;
            vectors++;
            if (rdy !== 1'b1) begin
                miscompares++;
                $display("FAIL wr_s_ready: got %b want 1 (beat %0d)", rdy, k);
            end
            tick();
            start = 1'b0;
            if (s_valid && rdy) begin
                acc.push_back(cyc);
                k++;
            end
            budget++;
        end
        s_valid = 1'b0;
        vectors++;
        if (k != l) begin
            miscompares++;
            $display("FAIL wr_timeout: accepted %0d want %0d", k, l);
        end
        vectors++;
        if (s_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_ready_after: got %b want 0", s_ready);
        end
        repeat (3) tick();
        for (int i = 0; i < l; i++) ref_mem[(int'(b) + i) % NWORDS] = data[i];
        vectors++;
        if (wr_addr_q.size() != l) begin
            miscompares++;
            $display("FAIL wr_count: got %0d want %0d", wr_addr_q.size(), l);
        end
        for (int i = 0; i < l && i < wr_addr_q.size() && i < acc.size(); i++) begin
            idx = (int'(b) + i) % NWORDS;
            vectors++;
            if (wr_addr_q[i] !== AW'(idx) || wr_data_q[i] !== data[i] ||
                wr_cyc_q[i] != acc[i]) begin
                miscompares++;
                $display("FAIL wr_beat%0d: got addr %0d data %0h cyc %0d want %0d %0h %0d",
                         i, wr_addr_q[i], wr_data_q[i], wr_cyc_q[i], idx, data[i], acc[i]);
            end
        end
        vectors++;
        if (done_q.size() != 1 || (acc.size() > 0 && done_q[0] != acc[acc.size()-1])) begin
            miscompares++;
            $display("FAIL wr_done: got %0d pulses first %0d want 1 at %0d", done_q.size(),
                     done_q.size() > 0 ? done_q[0] : -1,
                     acc.size() > 0 ? acc[acc.size()-1] : -1);
        end
        vectors++;
        if (rd_cyc_q.size() != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_idle: reads %0d busy %b want 0 0", rd_cyc_q.size(), busy);
        end
        if (vmode == 0) begin
            vectors++;
            if (wr_cyc_q.size() > 0 && wr_cyc_q[0] != t0 + 1) begin
                miscompares++;
                $display("FAIL wr_first: got cyc %0d want %0d", wr_cyc_q[0], t0 + 1);
            end
        end
    endtask

    // rmode: 0 ready held, 1 random ready, 2 ready low for 12 cycles then high.
    task automatic run_read(input logic [AW-1:0] b, input int l, input int rmode);
        int            t0, got, budget, first_valid, last_pop, idx;
        logic [DW-1:0] exp;
        clear_mon();
        issue(1'b1, b, l, t0);
        got = 0;
        budget = 0;
        first_valid = -1;
        last_pop = -1;
        while (got < l && budget < 400) begin
            case (rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'($urandom);
                default: m_ready = (budget >= 12);
            endcase
            if (rmode == 2 && budget == 11) begin
                vectors++;
                if (rd_cyc_q.size() != OD || ram_cs !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rd_backpressure: issues %0d cs %b want %0d 0",
                             rd_cyc_q.size(), ram_cs, OD);
                end
            end
            if (m_valid === 1'b1 && first_valid < 0) first_valid = cyc;
            if (m_valid === 1'b1 && m_ready) begin
                idx = (int'(b) + got) % NWORDS;
                exp = ref_mem[idx];
                vectors++;
                if (m_data !== exp) begin
                    miscompares++;
                    $display("FAIL rd_word%0d: got %0h want %0h (addr %0d)", got, m_data, exp, idx);
                end
                last_pop = cyc + 1;
                got++;
            end
            tick();
            budget++;
        end
        m_ready = 1'b0;
        vectors++;
        if (got != l) begin
            miscompares++;
            $display("FAIL rd_timeout: popped %0d want %0d", got, l);
        end
        repeat (3) tick();
        vectors++;
        if (done_q.size() != 1 || (done_q.size() > 0 && done_q[0] != last_pop)) begin
            miscompares++;
            $display("FAIL rd_done: got %0d pulses first %0d want 1 at %0d", done_q.size(),
                     done_q.size() > 0 ? done_q[0] : -1, last_pop);
        end
        vectors++;
        if (rd_cyc_q.size() != l || wr_cyc_q.size() != 0 || m_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_tail: issues %0d writes %0d m_valid %b busy %b want %0d 0 0 0",
                     rd_cyc_q.size(), wr_cyc_q.size(), m_valid, busy, l);
        end
        if (rmode == 0) begin
            vectors++;
            if (rd_cyc_q.size() == 0 || rd_cyc_q[0] != t0 + 1 || first_valid != t0 + 3 ||
                last_pop != t0 + l + 3) begin
                miscompares++;
                $display("FAIL rd_timing: issue %0d valid %0d lastpop %0d want %0d %0d %0d",
                         rd_cyc_q.size() > 0 ? rd_cyc_q[0] : -1, first_valid, last_pop,
                         t0 + 1, t0 + 3, t0 + l + 3);
            end
        end
    endtask

    task automatic test_reset();
        rst_n_0 = 1'b0;
        start = 1'b1;
        s_valid = 1'b1;
        repeat (2) tick();
        vectors++;
        if ({busy, done, s_ready, m_valid, ram_cs, ram_we, ram_oe} !== 7'b0 ||
            m_data !== '0 || ram_addr !== '0 || ram_din !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got ctl %b data %0h addr %0h din %0h want all 0",
                     {busy, done, s_ready, m_valid, ram_cs, ram_we, ram_oe},
                     m_data, ram_addr, ram_din);
        end
        start = 1'b0;
        s_valid = 1'b0;
        rst_n_0 = 1'b1;
        tick();
        vectors++;
        if (busy !== 1'b0 || s_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: busy %b s_ready %b want 0 0", busy, s_ready);
        end
    endtask

    task automatic test_len0();
        int t0;
        clear_mon();
        issue(1'($urandom), AW'($urandom), 0, t0);
        vectors++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL len0_done: done %b busy %b want 1 1", done, busy);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL len0_after: done %b busy %b want 0 0", done, busy);
        end
        tick();
        vectors++;
        if (wr_cyc_q.size() + rd_cyc_q.size() != 0 || done_q.size() != 1) begin
            miscompares++;
            $display("FAIL len0_cs: ram cycles %0d dones %0d want 0 1",
                     wr_cyc_q.size() + rd_cyc_q.size(), done_q.size());
        end
    endtask

    task automatic test_reset_mid_read();
        int t0, got, budget;
        clear_mon();
        issue(1'b1, AW'(0), 8, t0);
        got = 0;
        budget = 0;
        m_ready = 1'b1;
        while (got < 2 && budget < 50) begin
            if (m_valid === 1'b1) got++;
            tick();
            budget++;
        end
        #2;
        rst_n_0 = 1'b0;
        #1;
        vectors++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || ram_cs !== 1'b0 || got != 2) begin
            miscompares++;
            $display("FAIL rst_mid_read: m_valid %b busy %b cs %b pops %0d want 0 0 0 2",
                     m_valid, busy, ram_cs, got);
        end
        repeat (2) tick();
        rst_n_0 = 1'b1;
        m_ready = 1'b0;
        repeat (2) tick();
        vectors++;
        if (done_q.size() != 0) begin
            miscompares++;
            $display("FAIL rst_no_done: got %0d pulses want 0", done_q.size());
        end
        run_read(AW'(0), 4, 0);
    endtask

    task automatic test_random();
        logic [AW-1:0] b;
        int            l;
        for (int it = 0; it < 6; it++) begin
            b = AW'($urandom);
            l = int'($urandom_range(1, 20));
            run_write(b, l, int'($urandom_range(0, 2)), 0, 0);
            run_read(b, l, 1);
        end
    endtask

    initial begin
        for (int i = 0; i < NWORDS; i++) begin
            ram_arr[i] = '0;
            ref_mem[i] = '0;
        end
        test_reset();
        run_write(AW'(0), 4, 0, 1, 0);
        run_read(AW'(0), 4, 0);
        run_write(AW'(16), 8, 0, 0, 0);
        run_read(AW'(16), 8, 2);
        run_write(AW'(254), 4, 0, 0, 0);
        run_read(AW'(254), 4, 0);
        test_len0();
        run_write(AW'(40), 4, 0, 0, 1);
        run_read(AW'(40), 4, 0);
        run_write(AW'(80), 4, 1, 0, 0);
        run_read(AW'(80), 4, 1);
        test_random();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
